hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/pipe_pkg.sv | 6 +
 rtl/fwd_unit.sv | 15 +
 rtl/hazard_ctrl.sv | 96 +++++++++
 tb/tb_hazard_ctrl.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared hazard-control types and defaults
package pipe_pkg;
  typedef enum logic [1:0] {RUN, WAIT, FAULT} state_t;
  typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10} fwd_sel_t;
  localparam int MEM_TIMEOUT_DEF = 255;
endpackage

// File: rtl/fwd_unit.sv
// fwd_unit: operand bypass select for one Execute source register
module fwd_unit
  import pipe_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] rd_m,
  input  logic       reg_write_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_w,
  output fwd_sel_t   sel
);
  always_comb
    sel = (reg_write_m && rd_m != '0 && rd_m == rs) ? FWD_MEM :
          (reg_write_w && rd_w != '0 && rd_w == rs) ? FWD_WB : FWD_RF;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding, load-use/branch hazards, memory-wait FSM and perf counters
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1D,
  input  logic [4:0]       rs2D,
  input  logic [4:0]       rs1E,
  input  logic [4:0]       rs2E,
  input  logic [4:0]       rdE,
  input  logic             LoadE,
  input  logic             PCSrcE,
  input  logic [4:0]       rdM,
  input  logic             RegWriteM,
  input  logic [4:0]       rdW,
  input  logic             RegWriteW,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  input  logic             PerfClr,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MemFault,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  state_t           state_q, state_d;
  logic [WW-1:0]    wcnt_q, wcnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic             lw_stall, mem_stall;
  fwd_sel_t         fwd_a, fwd_b;
  fwd_unit u_fwd_a (.rs(rs1E), .rd_m(rdM), .reg_write_m(RegWriteM), .rd_w(rdW), .reg_write_w(RegWriteW), .sel(fwd_a));
  fwd_unit u_fwd_b (.rs(rs2E), .rd_m(rdM), .reg_write_m(RegWriteM), .rd_w(rdW), .reg_write_w(RegWriteW), .sel(fwd_b));
  assign ForwardAE = fwd_a;
  assign ForwardBE = fwd_b;
  assign MemFault  = state_q == FAULT;
  assign StallCnt  = stall_cnt_q;
  assign FlushCnt  = flush_cnt_q;
  // a memory stall freezes the whole pipe and defers branch/load-use bubbles
  always_comb begin
    lw_stall  = LoadE && rdE != '0 && (rdE == rs1D || rdE == rs2D);
    mem_stall = state_q == RUN  ? MemReqM && !MemReadyM :
                state_q == WAIT ? !MemReadyM : 1'b1;
    StallF = mem_stall || lw_stall;
    StallD = StallF;
    StallE = mem_stall;
    StallM = mem_stall;
    FlushW = mem_stall;
    FlushD = !mem_stall && PCSrcE;
    FlushE = !mem_stall && (lw_stall || PCSrcE);
    stall_cnt_d = PerfClr ? '0 : (StallF && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    flush_cnt_d = PerfClr ? '0 : (PCSrcE && !mem_stall && !(&flush_cnt_q)) ? flush_cnt_q + 1'b1 : flush_cnt_q;
  end
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      RUN: if (MemReqM && !MemReadyM) begin
        state_d = WAIT;
        wcnt_d  = WW'(1);
      end
      WAIT: if (MemReadyM) begin
        state_d = RUN;
        wcnt_d  = '0;
      end else if (wcnt_q == WW'(MEM_TIMEOUT)) begin
        state_d = FAULT;
      end else begin
        wcnt_d = wcnt_q + 1'b1;
      end
      default: state_d = FAULT;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= RUN;
      wcnt_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vector table plus hand-written memory-wait, timeout and counter sequences
module tb_hazard_ctrl;
  logic clk, rst_n;
  logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic LoadE, PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM, PerfClr;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemFault;
  logic [1:0] ForwardAE, ForwardBE;
  logic [3:0] StallCnt, FlushCnt;
  int pass = 0, total = 0;

  typedef struct {
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde;
    logic lde, pcs;
    logic [4:0] rdm;
    logic rwm;
    logic [4:0] rdw;
    logic rww;
    logic sf, fd, fe;
    logic [1:0] fa, fb;
  } vec_t;
  vec_t v[13];

  hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
    .LoadE(LoadE), .PCSrcE(PCSrcE), .rdM(rdM), .RegWriteM(RegWriteM), .rdW(rdW), .RegWriteW(RegWriteW),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM), .PerfClr(PerfClr),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .MemFault(MemFault),
    .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic clr_in();
    {rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW} = '0;
    {LoadE, PCSrcE, RegWriteM, RegWriteW, MemReqM, PerfClr} = '0;
    MemReadyM = 1'b1;
  endtask

  task automatic drive(input vec_t x);
    rs1D = x.rs1d; rs2D = x.rs2d; rs1E = x.rs1e; rs2E = x.rs2e; rdE = x.rde;
    LoadE = x.lde; PCSrcE = x.pcs; rdM = x.rdm; RegWriteM = x.rwm; rdW = x.rdw; RegWriteW = x.rww;
  endtask

  // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}
  function automatic logic [6:0] ctl();
    return {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};
  endfunction

  initial begin
    v[0]  = '{0, 0, 5, 0, 0, 0, 0, 5, 1, 5, 1, 0, 0, 0, 2'b10, 2'b00};
    v[1]  = '{0, 0, 5, 0, 0, 0, 0, 0, 1, 5, 1, 0, 0, 0, 2'b01, 2'b00};
    v[2]  = '{0, 0, 0, 7, 0, 0, 0, 7, 0, 7, 1, 0, 0, 0, 2'b00, 2'b01};
    v[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00};
    v[4]  = '{0, 0, 9, 0, 0, 0, 0, 9, 0, 9, 0, 0, 0, 0, 2'b00, 2'b00};
    v[5]  = '{0, 0, 4, 4, 0, 0, 0, 4, 1, 4, 1, 0, 0, 0, 2'b10, 2'b10};
    v[6]  = '{0, 3, 0, 0, 3, 1, 0, 0, 0, 0, 0, 1, 0, 1, 2'b00, 2'b00};
    v[7]  = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00};
    v[8]  = '{3, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00};
    v[9]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00};
    v[10] = '{6, 0, 0, 0, 6, 1, 1, 0, 0, 0, 0, 1, 1, 1, 2'b00, 2'b00};
    v[11] = '{2, 9, 0, 0, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00};
    v[12] = '{0, 0, 12, 13, 0, 0, 0, 12, 1, 13, 1, 0, 0, 0, 2'b10, 2'b01};

    clr_in();
    rst_n = 1'b0;
    #3;
    chk("reset ctl", ctl(), 7'b0);
    chk("reset fault/cnt", {MemFault, StallCnt, FlushCnt}, 9'b0);
    LoadE = 1'b1; rdE = 5'd3; rs1D = 5'd3;
    #1;
    chk("reset lw ctl", ctl(), 7'b1100010);
    clr_in();
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      @(negedge clk) drive(v[i]);
      #1;
      chk($sformatf("v%0d ctl", i), ctl(), {v[i].sf, v[i].sf, 2'b00, v[i].fd, v[i].fe, 1'b0});
      chk($sformatf("v%0d fwd", i), {ForwardAE, ForwardBE}, {v[i].fa, v[i].fb});
    end

    @(negedge clk) begin clr_in(); PerfClr = 1'b1; end
    @(negedge clk) PerfClr = 1'b0;
    #1 chk("perfclr cnt", {StallCnt, FlushCnt}, 8'h00);

    @(negedge clk) begin LoadE = 1'b1; rdE = 5'd3; rs2D = 5'd3; end
    #1 chk("lw ctl", ctl(), 7'b1100010);
    @(negedge clk) clr_in();
    #1 chk("lw cnt", {StallCnt, FlushCnt}, 8'h10);

    @(negedge clk) begin drive(v[10]); end
    #1 chk("br+lw ctl", ctl(), 7'b1100110);
    @(negedge clk) clr_in();
    #1 chk("br+lw cnt", {StallCnt, FlushCnt}, 8'h21);

    @(negedge clk) begin MemReqM = 1'b1; MemReadyM = 1'b0; PCSrcE = 1'b1; end
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      #1 chk($sformatf("memwait c%0d ctl", c), ctl(), 7'b1111001);
    end
    @(negedge clk) MemReadyM = 1'b1;
    #1 chk("mem release ctl", ctl(), 7'b0000110);
    @(negedge clk) begin MemReqM = 1'b0; MemReadyM = 1'b0; PCSrcE = 1'b0; end
    #1 chk("back in run ctl", ctl(), 7'b0);
    chk("memwait cnt", {StallCnt, FlushCnt}, 8'h52);

    @(negedge clk) begin MemReqM = 1'b1; MemReadyM = 1'b0; end
    #1 chk("to run stall", ctl(), 7'b1111001);
    repeat (4) @(negedge clk);
    #1 chk("to wait4 fault", {MemFault, StallF}, 2'b01);
    @(negedge clk);
    #1 chk("to fault", {MemFault, StallF}, 2'b11);
    @(negedge clk) begin MemReqM = 1'b0; MemReadyM = 1'b1; end
    #1 chk("fault sticky ctl", {MemFault, ctl()}, 8'b11111001);
    rst_n = 1'b0;
    #1 chk("fault reset", {MemFault, ctl(), StallCnt, FlushCnt}, 16'h0);
    @(negedge clk) begin rst_n = 1'b1; MemReadyM = 1'b0; end
    @(negedge clk);
    #1 chk("post reset run", {MemFault, ctl()}, 8'h00);

    @(negedge clk) begin MemReqM = 1'b1; MemReadyM = 1'b0; end
    repeat (2) @(negedge clk);
    begin MemReqM = 1'b0; rst_n = 1'b0; end
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    #1 chk("midwait reset", {MemFault, ctl()}, 8'h00);

    @(negedge clk) drive(v[10]);
    repeat (20) @(negedge clk);
    #1 chk("saturate", {StallCnt, FlushCnt}, 8'hff);
    PerfClr = 1'b1;
    @(negedge clk) clr_in();
    #1 chk("perfclr priority", {StallCnt, FlushCnt}, 8'h00);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
